// File: rtl/two_way_mux_component_pkg.sv
// Shared defaults for the two-way mux component and its selection counters.
package two_way_mux_component_pkg;

  localparam int WIDTH_DEF     = 16;
  localparam int CNT_WIDTH_DEF = 16;

endpackage

// File: rtl/two_way_mux_component_sat_counter.sv
// Unsigned up-counter that stops at all-ones instead of wrapping.
module sat_counter #(
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 inc,
  output logic [CNT_WIDTH-1:0] count
);

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (inc && (count != CNT_MAX)) begin
      count <= count + CNT_ONE;
    end
  end

endmodule

// File: rtl/two_way_mux_component.sv
// Two-input data mux with a registered copy of the result and per-input
// saturating selection counters.
module two_way_mux_component
  import two_way_mux_component_pkg::*;
#(
  parameter int WIDTH     = WIDTH_DEF,
  parameter int CNT_WIDTH = CNT_WIDTH_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [WIDTH-1:0]     in0,
  input  logic [WIDTH-1:0]     in1,
  input  logic                 op,
  output logic [WIDTH-1:0]     out,
  output logic [WIDTH-1:0]     out_q,
  output logic                 op_q,
  output logic [CNT_WIDTH-1:0] sel_count0,
  output logic [CNT_WIDTH-1:0] sel_count1
);

  logic sel1;

  // Only a definite 1 picks in1; anything else (X/Z included) falls back to in0.
  assign sel1 = (op === 1'b1);
  assign out  = (op === 1'b1) ? in1 : in0;

  always_ff @(posedge clk) begin
    if (reset) begin
      out_q <= '0;
      op_q  <= 1'b0;
    end else begin
      out_q <= out;
      op_q  <= op;
    end
  end

  sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_cnt0 (
    .clk   (clk),
    .reset (reset),
    .inc   (~sel1),
    .count (sel_count0)
  );

  sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_cnt1 (
    .clk   (clk),
    .reset (reset),
    .inc   (sel1),
    .count (sel_count1)
  );

endmodule

// File: tb/tb_two_way_mux_component.sv
// Bench for two_way_mux_component: default-width instance plus a 4-bit-counter
// instance, checked against a behavioural model every cycle and by literal checks.
module tb_two_way_mux_component;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] in0, in1;
  logic        op;

  logic [15:0] out, out_q, c0, c1;
  logic        op_q;
  logic [15:0] s_out, s_out_q;
  logic        s_op_q;
  logic [3:0]  s_c0, s_c1;

  int total = 0;
  int bad   = 0;

  // model state
  bit          armed = 1'b0;
  logic [15:0] m_oq;
  logic        m_opq;
  int          m_c0, m_c1, m_s0, m_s1;

  always #5 clk = ~clk;

  two_way_mux_component dut (
    .clk(clk), .reset(reset), .in0(in0), .in1(in1), .op(op),
    .out(out), .out_q(out_q), .op_q(op_q),
    .sel_count0(c0), .sel_count1(c1)
  );

  two_way_mux_component #(.WIDTH(16), .CNT_WIDTH(4)) dut_s (
    .clk(clk), .reset(reset), .in0(in0), .in1(in1), .op(op),
    .out(s_out), .out_q(s_out_q), .op_q(s_op_q),
    .sel_count0(s_c0), .sel_count1(s_c1)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    if (reset) begin
      m_oq = '0; m_opq = 1'b0;
      m_c0 = 0; m_c1 = 0; m_s0 = 0; m_s1 = 0;
      armed = 1'b1;
    end else begin
      m_oq  = (op === 1'b1) ? in1 : in0;
      m_opq = op;
      if (op === 1'b1) begin
        if (m_c1 < 65535) m_c1++;
        if (m_s1 < 15)    m_s1++;
      end else begin
        if (m_c0 < 65535) m_c0++;
        if (m_s0 < 15)    m_s0++;
      end
    end
  end

  always @(posedge clk) begin
    #2;
    if (armed) begin
      chk("model_out",    out,     (op === 1'b1) ? in1 : in0);
      chk("model_out_s",  s_out,   (op === 1'b1) ? in1 : in0);
      chk("model_out_q",  out_q,   m_oq);
      chk("model_out_qs", s_out_q, m_oq);
      chk("model_op_q",   op_q,    m_opq);
      chk("model_op_qs",  s_op_q,  m_opq);
      chk("model_cnt0",   c0,      m_c0);
      chk("model_cnt1",   c1,      m_c1);
      chk("model_cnt0s",  s_c0,    m_s0);
      chk("model_cnt1s",  s_c1,    m_s1);
    end
  end

  initial begin
    reset = 1'b1; op = 1'b0; in0 = '0; in1 = '0;
    repeat (2) @(negedge clk);

    // select rule with no clock edge
    reset = 1'b0; op = 1'b0; in0 = 16'h0000; in1 = 16'h0001;
    #1 chk("lit_out_op0", out, 16'h0000);
    op = 1'b1;
    #1 chk("lit_out_op1", out, 16'h0001);
    @(posedge clk); #2;
    chk("lit_out_q_op1", out_q, 16'h0001);
    chk("lit_op_q_op1",  op_q,  1'b1);
    chk("lit_cnt1_one",  c1,    16'd1);

    // long reset with arbitrary inputs; out keeps following op
    @(negedge clk);
    reset = 1'b1; op = 1'b1; in0 = 16'h1234; in1 = 16'h5678;
    @(posedge clk); #2;
    chk("lit_rst_out_q", out_q, 16'h0000);
    chk("lit_rst_op_q",  op_q,  1'b0);
    chk("lit_rst_cnt0",  c0,    16'd0);
    chk("lit_rst_cnt1",  c1,    16'd0);
    chk("lit_rst_out",   out,   16'h5678);
    for (int i = 0; i < 49; i++) begin
      @(negedge clk);
      in0 = 16'($urandom); in1 = 16'($urandom); op = 1'($urandom);
      #1 chk("lit_rst_follow", out, op ? in1 : in0);
    end

    // 5 cycles of in1 then 3 of in0
    @(negedge clk);
    reset = 1'b0; op = 1'b1; in0 = 16'hAAAA; in1 = 16'h5555;
    repeat (5) @(negedge clk);
    op = 1'b0;
    repeat (3) @(negedge clk);
    chk("lit_cnt1_five",  c1,   16'd5);
    chk("lit_cnt0_three", c0,   16'd3);
    chk("lit_s_cnt1",     s_c1, 4'd5);
    chk("lit_out_q_in0",  out_q, 16'hAAAA);

    // one-cycle reset mid-count, then resume from zero
    op = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("lit_mid_cnt0",  c0,    16'd0);
    chk("lit_mid_cnt1",  c1,    16'd0);
    chk("lit_mid_out_q", out_q, 16'h0000);
    chk("lit_mid_op_q",  op_q,  1'b0);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("lit_resume_cnt1", c1, 16'd3);
    chk("lit_resume_cnt0", c0, 16'd0);

    // saturation of the 4-bit counters
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0; op = 1'b1;
    repeat (20) @(negedge clk);
    chk("lit_sat_cnt1", s_c1, 4'd15);
    chk("lit_sat_cnt0", s_c0, 4'd0);
    chk("lit_wide_cnt1", c1,  16'd20);
    op = 1'b0;
    repeat (2) @(negedge clk);
    chk("lit_sat_hold", s_c1, 4'd15);
    chk("lit_sat_other", s_c0, 4'd2);

    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/two_way_mux_component.md
TWO_WAY_MUX_COMPONENT -- requirements
Module: two_way_mux_component

Interface
REQ-001 Parameter WIDTH, default 16: data width of in0, in1, out and out_q.
REQ-002 Parameter CNT_WIDTH, default 16: width of each selection counter.
REQ-003 Single clock; reset is synchronous and active-high.
REQ-004 clk  input  1  clock; all registers update on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 in0  input  WIDTH  data input selected when op=0.
REQ-007 in1  input  WIDTH  data input selected when op=1.
REQ-008 op  input  1  select control.
REQ-009 out  output  WIDTH  combinational mux result.
REQ-010 out_q  output  WIDTH  registered copy of out.
REQ-011 op_q  output  1  registered copy of op.
REQ-012 sel_count0  output  CNT_WIDTH  number of clock cycles in which in0 was selected.
REQ-013 sel_count1  output  CNT_WIDTH  number of clock cycles in which in1 was selected.

Function
REQ-014 out SHALL equal in0 when op=0 and in1 when op=1, with no clock latency.
REQ-015 out SHALL settle in the same delta/time step as any input change.
REQ-016 out SHALL be combinational and independent of reset; it SHALL follow the select rule while reset is asserted.
REQ-017 Any op value other than 1 (including X/Z in simulation) SHALL select in0.
REQ-018 out_q SHALL capture out on each rising clk edge while reset=0, giving 1 cycle of latency.
REQ-019 op_q SHALL capture op on each rising clk edge while reset=0.
REQ-020 On each non-reset rising edge, sel_count1 SHALL increment when op=1; otherwise sel_count0 SHALL increment.
REQ-021 Exactly one counter SHALL increment per non-reset cycle.
REQ-022 Each counter SHALL saturate at 2^CNT_WIDTH-1 and SHALL never wrap.
REQ-023 A counter at saturation SHALL not affect the other counter.
REQ-024 Both counters SHALL be unsigned.
REQ-025 The design SHALL have no handshake and no state machine.

Reset
REQ-026 When reset=1 at a rising clk edge, out_q, op_q, sel_count0 and sel_count1 SHALL all become 0.
REQ-027 Reset SHALL take priority over capture and counting in the same cycle.
REQ-028 Reset asserted mid-operation SHALL clear the registers at the next edge only; there SHALL be no asynchronous effect.
REQ-029 out SHALL not be affected by reset (see REQ-016).

Structure
REQ-030 A shared package SHALL hold the WIDTH and CNT_WIDTH default constants.
REQ-031 One sub-module, sat_counter (parameter CNT_WIDTH; ports clk, reset, inc, count), SHALL be instantiated twice, once per selection counter.
REQ-032 The mux data path SHALL be a single continuous assignment.
REQ-033 No latches SHALL be inferred.

Verification
REQ-034 After reset deasserts, op=0, in0=0x0000, in1=0x0001 -> out=0x0000 immediately, with no clock edge.
REQ-035 op=1, in0=0x0000, in1=0x0001 -> out=0x0001 immediately; after the next edge, out_q=0x0001 and op_q=1.
REQ-036 reset=1 for 100 half-periods with arbitrary inputs -> out_q=0, op_q=0 and both counters=0 after the first edge, while out still follows op.
REQ-037 After reset, op=1 for 5 cycles then op=0 for 3 cycles -> sel_count1=5 and sel_count0=3.
REQ-038 With CNT_WIDTH=4, op=1 for 20 cycles -> sel_count1 holds at 15 and sel_count0 stays 0.
REQ-039 Assert reset for one cycle mid-count -> all registers read 0 at the next edge, and counting resumes from 0 afterwards.
